// File: rtl/shift_32_iter_pkg.sv
// shift_32_iter_pkg -- shared definitions for the iterative 32-bit shifter.
//   * default operand / shift-amount widths
//   * shift op encodings (SLL/SRL/SRA/ROR)
//   * FSM state encodings (IDLE/SHIFT/DONE)
// Optional feature macro: SHIFT_32_ITER_ROTATE_EN (consumed by shift_1_stage).
package shift_32_iter_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int SHAMT_WIDTH = 5;

    typedef enum logic [1:0] {
        SHIFT_OP_SLL = 2'b00,
        SHIFT_OP_SRL = 2'b01,
        SHIFT_OP_SRA = 2'b10,
        SHIFT_OP_ROR = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_32_iter_if.sv
// shift_32_iter_if -- request/result bundle of the iterative shifter.
//   START  request, sampled on the rising clock edge
//   D      operand, sampled with START
//   S      shift amount (0..DATA_WIDTH-1), sampled with START
//   OP     shift op (see shift_op_e), sampled with START
//   Y      result register
//   BUSY   high while an operation is in progress
//   DONE   one-cycle completion pulse, Y valid
// master: requester side; slave: shifter side.
interface shift_32_iter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
);
    logic                   START;
    logic [DATA_WIDTH-1:0]  D;
    logic [SHAMT_WIDTH-1:0] S;
    logic [1:0]             OP;
    logic [DATA_WIDTH-1:0]  Y;
    logic                   BUSY;
    logic                   DONE;

    modport master (output START, D, S, OP, input  Y, BUSY, DONE);
    modport slave  (input  START, D, S, OP, output Y, BUSY, DONE);
endinterface

// File: rtl/shift_32_iter_shift_1_stage.sv
// shift_1_stage -- combinational single-position shift, one 2:1 mux chain
// per bit.
//   d_i   operand
//   op_i  shift op
//   q_o   operand shifted by one position
// With SHIFT_32_ITER_ROTATE_EN defined, op ROR rotates right (bit 0 -> MSB);
// otherwise op ROR passes the operand through unchanged.
module shift_1_stage
    import shift_32_iter_pkg::*;
#(
    parameter int DATA_WIDTH = shift_32_iter_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] d_i,
    input  shift_op_e             op_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic                  msb_fill;
    logic                  keep_sel;   // hold operand instead of shifting
    logic                  right_sel;  // right shift vs. left shift
    logic [DATA_WIDTH-1:0] left_v;
    logic [DATA_WIDTH-1:0] right_v;

`ifdef SHIFT_32_ITER_ROTATE_EN
    // vacated MSB: SRA -> sign, ROR -> old bit 0, SRL -> 0
    assign msb_fill = op_i[0] ? (op_i[1] ? d_i[0] : 1'b0)
                              : (op_i[1] ? d_i[DATA_WIDTH-1] : 1'b0);
    assign keep_sel = 1'b0;
`else
    assign msb_fill = (op_i == SHIFT_OP_SRA) ? d_i[DATA_WIDTH-1] : 1'b0;
    assign keep_sel = (op_i == SHIFT_OP_ROR);
`endif

    assign right_sel = (op_i != SHIFT_OP_SLL);
    assign left_v    = {d_i[DATA_WIDTH-2:0], 1'b0};
    assign right_v   = {msb_fill, d_i[DATA_WIDTH-1:1]};

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        logic shifted;
        assign shifted = right_sel ? right_v[i] : left_v[i];
        assign q_o[i]  = keep_sel  ? d_i[i]     : shifted;
    end

endmodule

// File: rtl/shift_32_iter.sv
// shift_32_iter -- multi-cycle iterative shifter, one bit position per clock.
//   CLK  system clock, rising edge
//   RST  asynchronous active-low reset
//   bus  shift_32_iter_if.slave: START/D/S/OP in, Y/BUSY/DONE out
// Latency: START sampled at edge k -> DONE high after edge k+S+1.
// Optional feature macro: SHIFT_32_ITER_ROTATE_EN (OP=11 rotate right).
module shift_32_iter
    import shift_32_iter_pkg::*;
#(
    parameter int DATA_WIDTH  = shift_32_iter_pkg::DATA_WIDTH,
    parameter int SHAMT_WIDTH = shift_32_iter_pkg::SHAMT_WIDTH
) (
    input  logic           CLK,
    input  logic           RST,
    shift_32_iter_if.slave bus
);

    shift_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0]  work_q,  work_d;
    logic [SHAMT_WIDTH-1:0] cnt_q,   cnt_d;
    shift_op_e              op_q,    op_d;
    logic [DATA_WIDTH-1:0]  y_q,     y_d;
    logic [DATA_WIDTH-1:0]  work_shift;

    shift_1_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
        .d_i (work_q),
        .op_i(op_q),
        .q_o (work_shift)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= SHIFT_OP_SLL;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        y_d     = y_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // a START in the DONE cycle is taken with no bubble
                if (bus.START) begin
                    work_d  = bus.D;
                    cnt_d   = bus.S;
                    op_d    = shift_op_e'(bus.OP);
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // START is ignored here; the running op is unaffected
                if (cnt_q != '0) begin
                    work_d = work_shift;
                    cnt_d  = cnt_q - SHAMT_WIDTH'(1);
                end else begin
                    y_d     = work_q;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.Y    = y_q;
    assign bus.BUSY = (state_q == ST_SHIFT);
    assign bus.DONE = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_32_iter.sv
// tb_shift_32_iter -- directed self-checking bench for shift_32_iter.
module tb_shift_32_iter;
    import shift_32_iter_pkg::*;

    logic CLK;
    logic RST;
    int   n_chk;
    int   n_err;

    shift_32_iter_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) bus ();

    shift_32_iter #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Drive one request; returns #1 after the edge that samples START.
    task automatic pulse_start(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        @(negedge CLK);
        bus.START = 1'b1;
        bus.D     = d;
        bus.S     = s;
        bus.OP    = op;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        bus.D     = ~d;   // later input changes must not matter
        bus.S     = ~s;
        bus.OP    = ~op;
    endtask

    // Edges counted from the START edge until DONE is seen.
    task automatic wait_done(input string tag, output int n, output int busy_n, output int ychg);
        logic [31:0] y0;
        y0     = bus.Y;
        n      = 0;
        busy_n = 0;
        ychg   = 0;
        while (n < 200) begin
            if (bus.BUSY) busy_n++;
            if (bus.DONE) break;
            if (bus.Y !== y0) ychg++;
            @(posedge CLK);
            #1;
            n++;
        end
        if (n >= 200) chk({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                          input logic [1:0] op, input logic [31:0] exp_y);
        int n, busy_n, ychg;
        pulse_start(d, s, op);
        wait_done(tag, n, busy_n, ychg);
        chk({tag, "_lat"},  n,      32'(s) + 32'd1);
        chk({tag, "_y"},    bus.Y,  exp_y);
        chk({tag, "_busy"}, busy_n, 32'(s) + 32'd1);
        chk({tag, "_ystb"}, ychg,   32'd0);
        @(posedge CLK);
        #1;
        chk({tag, "_pulse"}, {31'd0, bus.DONE}, 32'd0);
    endtask

    initial begin
        int n, busy_n, ychg, dcnt;
        logic [31:0] rot_exp;
        n_chk = 0;
        n_err = 0;
        RST       = 1'b0;
        bus.START = 1'b0;
        bus.D     = '0;
        bus.S     = '0;
        bus.OP    = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_y",    bus.Y,                32'd0);
        chk("rst_busy", {31'd0, bus.BUSY},    32'd0);
        chk("rst_done", {31'd0, bus.DONE},    32'd0);
        @(negedge CLK);
        RST = 1'b1;

        run_op("sll31",  32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
        run_op("srl4",   32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000);
        run_op("sra4",   32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000);
        run_op("s0",     32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF);
        run_op("sra31",  32'h8000_1234, 5'd31, 2'b10, 32'hFFFF_FFFF);
        run_op("srl31",  32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);
        run_op("sll8",   32'h1234_5678, 5'd8,  2'b00, 32'h3456_7800);
        run_op("sra3p",  32'h7000_0000, 5'd3,  2'b10, 32'h0E00_0000);

`ifdef SHIFT_32_ITER_ROTATE_EN
        rot_exp = 32'h8000_0000;
`else
        rot_exp = 32'h0000_0001;
`endif
        run_op("op11", 32'h0000_0001, 5'd1, 2'b11, rot_exp);

        // START while busy is ignored; START in the DONE cycle is accepted
        pulse_start(32'h0000_00F0, 5'd4, 2'b01);
        @(posedge CLK);
        #1;
        pulse_start(32'hFFFF_FFFF, 5'd1, 2'b00);
        wait_done("ign", n, busy_n, ychg);
        chk("ign_lat", n + 2, 32'd5);
        chk("ign_y",   bus.Y, 32'h0000_000F);
        pulse_start(32'h0000_0001, 5'd2, 2'b00);
        chk("b2b_busy", {31'd0, bus.BUSY}, 32'd1);
        chk("b2b_done", {31'd0, bus.DONE}, 32'd0);
        chk("b2b_yhold", bus.Y, 32'h0000_000F);
        wait_done("b2b", n, busy_n, ychg);
        chk("b2b_lat", n,     32'd3);
        chk("b2b_y",   bus.Y, 32'h0000_0004);
        @(posedge CLK);
        #1;

        // asynchronous reset mid-shift
        pulse_start(32'h0000_0001, 5'd20, 2'b00);
        repeat (5) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("arst_y",    bus.Y,             32'd0);
        chk("arst_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("arst_done", {31'd0, bus.DONE}, 32'd0);
        @(negedge CLK);
        RST  = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK);
            #1;
            if (bus.DONE || bus.BUSY) dcnt++;
        end
        chk("arst_nodone", dcnt, 32'd0);
        run_op("post", 32'h0000_0F00, 5'd8, 2'b01, 32'h0000_000F);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_32_iter.md
Name: shift_32_iter

Overview:
- Multi-cycle iterative 32-bit shifter for the DaVinci datapath.
- Sequential counterpart to the combinational 32-bit gate-level logic primitives (AND/OR/NOR/INV/BUF).
- Takes an operand, a shift amount and an op, shifts one bit position per clock, then presents the result with a one-cycle DONE pulse.
- Serves the ALU's shift ops when a gate-level barrel shifter is too costly.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount width; must equal log2(DATA_WIDTH).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous active-low reset.
- START  input  1  request; sampled on a rising edge of CLK.
- D  input  DATA_WIDTH  operand; sampled with START.
- S  input  SHAMT_WIDTH  shift amount, unsigned 0..31; sampled with START.
- OP  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 see Optional Feature; sampled with START.
- Y  output  DATA_WIDTH  result register.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse; Y is valid.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, Y=0, BUSY=0, DONE=0, working reg=0, CNT=0. Any in-flight operation is discarded with no DONE. Release is synchronous to the next CLK edge.
- States: IDLE, SHIFT, DONE.
- IDLE or DONE, START=1 at an edge:
  - latch D into the working reg, S into CNT, OP into op reg;
  - go to SHIFT.
- DONE, START=0: go to IDLE.
- SHIFT, CNT!=0 at each edge:
  - shift working reg by one position per op, CNT=CNT-1.
  - SLL fills 0 at bit 0. SRL fills 0 at bit 31. SRA replicates bit 31.
- SHIFT, CNT==0: Y<=working reg, go to DONE.
- Outputs: BUSY = (state==SHIFT). DONE = (state==DONE); it lasts exactly one cycle unless a back-to-back START arrives, and even then it stays a single cycle.
- Latency: START sampled at edge k → DONE high in the cycle after edge k+S+1. For S=0 the latency is 1.
- Y changes only on entry to DONE and holds until the next completion or reset. It is stable during SHIFT.
- START while BUSY=1 is ignored; the operation in progress is unaffected and no error is flagged.
- START in the DONE cycle is accepted with no bubble. DONE still pulses for the completed operation.
- D/S/OP changes after the START edge have no effect.
- S=31, SRA on a negative operand → 0xFFFF_FFFF. S=31, SRL → bit 31 moves to bit 0.

Optional Feature:
- Macro: SHIFT_32_ITER_ROTATE_EN.
- Defined: OP=11 is rotate right by one per cycle (bit 0 → bit 31), same latency.
- Undefined: OP=11 returns D unchanged (no shift), with the same S+1 latency and handshake, so timing is op-independent.

Decomposition:
- Shared package/header holds:
  - op encodings: SHIFT_OP_SLL=2'b00, SHIFT_OP_SRL=2'b01, SHIFT_OP_SRA=2'b10, SHIFT_OP_ROR=2'b11;
  - state encodings IDLE/SHIFT/DONE;
  - DATA_WIDTH and SHAMT_WIDTH defaults.
- One sub-module, shift_1_stage: combinational single-position shift of DATA_WIDTH bits selected by op, built from 2:1 mux gates. The top holds the FSM, CNT down-counter, working reg and Y reg.

Test Plan:
- SLL, D=0x0000_0001, S=31 → DONE 32 cycles after START, Y=0x8000_0000, BUSY high for 32 cycles.
- SRL D=0x8000_0000 S=4 → Y=0x0800_0000. SRA with the same D/S → Y=0xF800_0000. Each has DONE 5 cycles after START.
- S=0, OP=SLL, D=0xDEAD_BEEF → DONE 1 cycle after START, Y=0xDEAD_BEEF.
- START D=0x0000_00F0 S=4 SRL, then START with D=0xFFFF_FFFF two cycles later while BUSY → second START ignored, Y=0x0000_000F. A START in the DONE cycle is accepted.
- RST low for one cycle mid-SHIFT (S=20, after 5 cycles) → Y=0, BUSY=0, DONE=0 immediately. No DONE follows. A new START after release completes normally.
- OP=11, D=0x0000_0001, S=1:
  - with SHIFT_32_ITER_ROTATE_EN → Y=0x8000_0000;
  - without it → Y=0x0000_0001.
  - DONE 2 cycles after START in both builds.
